instr_encoder: RTL
==================

Name: instr_encoder

Overview:
Encodes RV32I instruction fields (opcode, func3, func7, register numbers, full 32-bit immediate) into 32-bit instruction words. Writes the words sequentially into instruction memory with a valid/ready input handshake and an ack-based write port. It is the exact inverse of the team's immediate decoder: for every word it writes, decoding returns the same `imm`. It is used by the test loader and the self-hosting program loader to fill instruction memory before the core runs.

Parameters:
- BaseAddr, 32'h0, byte address of the first word written.
- Depth, 1024, capacity in words; the write index saturates here.

Ports:
- `clk`, input, 1, clock, rising edge.
- `reset`, input, 1, asynchronous active-low reset; 0 = reset.
- `clear`, input, 1, synchronous: zero the count, drop the error, return to IDLE.
- `inValid`, input, 1, field bundle valid.
- `inReady`, output, 1, encoder accepts the bundle this cycle.
- `opcode`, input, 7, instruction opcode.
- `func3`, input, 3, func3 field.
- `func7`, input, 7, func7 field (R-format only).
- `regWriteNum`, input, 5, rd.
- `regNum0`, input, 5, rs1.
- `regNum1`, input, 5, rs2.
- `imm`, input, 32, full immediate value, exactly as the decoder produces it.
- `memWriteEnable`, output, 1, write request.
- `memWriteAddr`, output, 32, byte address, equal to BaseAddr + 4*count.
- `memWriteData`, output, 32, encoded word.
- `memAck`, input, 1, memory accepted the write.
- `count`, output, $clog2(Depth)+1, number of words written.
- `full`, output, 1, count == Depth.
- `err`, output, 1, sticky error flag.
- `errCode`, output, 2, error cause: 00 none, 01 bad opcode, 10 imm out of range, 11 imm misaligned.

Behaviour:
- Reset (`reset`=0, asynchronous): state=IDLE, `count`=0, `err`=0, `errCode`=00, `memWriteEnable`=0, `memWriteData`=0, `inReady`=0 while reset is held.
- Format is selected from `opcode`:
  - R: 0110011.
  - I: 0010011, 1100111, 0000011.
  - S: 0100011.
  - B: 1100011.
  - U: 0010111, 0110111.
  - J: 1101111.
  - Any other opcode is error 01.
- Encoding; all formats place opcode at [6:0], rd at [11:7], func3 at [14:12], rs1 at [19:15], rs2 at [24:20] where the format has them:
  - R: [31:25]=`func7`.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Immediate range checks (error 10 on failure):
  - I with func3 001 or 101: imm in 0..4095, unsigned, because the decoder zero-extends these. This applies to loads too.
  - Other I and S: signed -2048..2047.
  - B: signed -4096..4094.
  - J: signed -2^20..2^20-2.
- Alignment checks (error 11): B and J require imm[0]=0; U requires imm[11:0]=0.
- If more than one error applies, priority is 01 > 11 > 10.
- FSM:
  - IDLE: `inReady` = !`full` && !`err`. On `inValid`&&`inReady` the encoder registers the word and goes to WRITE; if the bundle has an error it sets `err`/`errCode` and goes to ERR instead.
  - WRITE: `memWriteEnable`=1, address and data held stable. On `memAck`: `count`++, go to IDLE. Without `memAck` it waits indefinitely.
  - ERR: `inReady`=0, no writes, stays until `clear`.
- Latency and throughput: a bundle accepted in cycle N raises `memWriteEnable` in cycle N+1. An ack in N+1 gives IDLE with `inReady`=1 in N+2. Peak throughput is 1 word per 2 cycles.
- `full`: the Depth-th ack drives `count`=Depth. `inReady` then stays 0; only `clear` or `reset` recover.
- `clear` has priority in every state. In WRITE it abandons the pending write: `memWriteEnable` drops next cycle and the word is not counted.
- `reset` asserted mid-WRITE drops `memWriteEnable` immediately (asynchronous).
- `memAck` outside WRITE is ignored.

Test Plan:
- Encode addi x1,x0,5 (opcode 0010011, func3 000, imm 5), ack immediately → `memWriteData`=0x00500093 at `memWriteAddr` 0x0, then `count`=1.
- Encode sw x2,8(x1), lui x5 with imm 0x12345000, beq x0,x0 with imm 0xFFFFFFFC, and jal x1 with imm 0x800, back to back → words 0x0020A423, 0x123452B7, 0xFE000EE3, 0x001000EF at byte addresses 0x0, 0x4, 0x8, 0xC.
- Check error cases; each requires `err`=1, no `memWriteEnable`, `inReady` low until `clear` with `count` unchanged:
  - B-format with imm=3 → `errCode`=11.
  - I-format slli (func3 001) with imm=0xFFFFFFFF → `errCode`=10.
  - Opcode 0000000 → `errCode`=01.
- Hold `memAck`=0 for 5 cycles in WRITE → `memWriteEnable`, address and data stable, `inReady`=0; ack on cycle 6 → `count` increments exactly once.
- Depth=2: write 2 words, present a third with `inValid`=1 → `full`=1, `inReady`=0. Pulse `clear` → `count`=0, the next write goes to BaseAddr.
- Assert `reset`=0 mid-WRITE → `memWriteEnable`=0 within the same cycle, `count`=0. Release `reset` → `inReady`=1 on the first clock edge after release.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs RV32I fields into instruction words and writes them
//            sequentially into instruction memory over an ack-based port.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [6:0]                opcode,
    input  logic [2:0]                func3,
    input  logic [6:0]                func7,
    input  logic [4:0]                regWriteNum,
    input  logic [4:0]                regNum0,
    input  logic [4:0]                regNum1,
    input  logic [31:0]               imm,
    output logic                      memWriteEnable,
    output logic [31:0]               memWriteAddr,
    output logic [31:0]               memWriteData,
    input  logic                      memAck,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      err,
    output logic [1:0]                errCode
);

    localparam int                     c_count_w = $clog2(DEPTH) + 1;
    localparam logic [c_count_w-1:0]   c_depth   = c_count_w'(DEPTH);
    localparam logic [c_count_w-1:0]   c_one     = c_count_w'(1);

    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    localparam logic [1:0] c_err_none  = 2'b00;
    localparam logic [1:0] c_err_op    = 2'b01;
    localparam logic [1:0] c_err_range = 2'b10;
    localparam logic [1:0] c_err_align = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_count_w-1:0]   r_count;
    logic                   r_err;
    logic [1:0]             r_code;
    logic                   r_we;
    logic                   r_ready;
    logic [31:0]            r_data;

    logic w_is_r, w_is_i, w_is_s, w_is_b, w_is_u, w_is_j, w_bad_op;
    logic w_fits12, w_fits13, w_fits21, w_uimm12, w_unsigned_i;
    logic w_misaligned, w_out_of_range;
    logic [31:0]            w_word;
    logic [1:0]             w_code;
    logic                   w_full;
    logic [c_count_w-1:0]   w_count_inc;

    assign w_is_r   = (opcode == c_op_reg);
    assign w_is_i   = (opcode == c_op_imm) || (opcode == c_op_jalr) || (opcode == c_op_load);
    assign w_is_s   = (opcode == c_op_store);
    assign w_is_b   = (opcode == c_op_branch);
    assign w_is_u   = (opcode == c_op_auipc) || (opcode == c_op_lui);
    assign w_is_j   = (opcode == c_op_jal);
    assign w_bad_op = !(w_is_r || w_is_i || w_is_s || w_is_b || w_is_u || w_is_j);

    // A value fits an N-bit signed field when every bit above it copies the sign.
    assign w_fits12     = (imm[31:11] == {21{imm[31]}});
    assign w_fits13     = (imm[31:12] == {20{imm[31]}});
    assign w_fits21     = (imm[31:20] == {12{imm[31]}});
    assign w_uimm12     = (imm[31:12] == 20'd0);
    assign w_unsigned_i = (func3 == 3'b001) || (func3 == 3'b101);

    always_comb begin
        w_word         = 32'd0;
        w_misaligned   = 1'b0;
        w_out_of_range = 1'b0;
        if (w_is_r) begin
            w_word = {func7, regNum1, regNum0, func3, regWriteNum, opcode};
        end else if (w_is_i) begin
            w_word         = {imm[11:0], regNum0, func3, regWriteNum, opcode};
            w_out_of_range = w_unsigned_i ? !w_uimm12 : !w_fits12;
        end else if (w_is_s) begin
            w_word         = {imm[11:5], regNum1, regNum0, func3, imm[4:0], opcode};
            w_out_of_range = !w_fits12;
        end else if (w_is_b) begin
            w_word         = {imm[12], imm[10:5], regNum1, regNum0, func3,
                              imm[4:1], imm[11], opcode};
            w_misaligned   = imm[0];
            w_out_of_range = !w_fits13;
        end else if (w_is_u) begin
            w_word         = {imm[31:12], regWriteNum, opcode};
            w_misaligned   = (imm[11:0] != 12'd0);
        end else if (w_is_j) begin
            w_word         = {imm[20], imm[10:1], imm[11], imm[19:12], regWriteNum, opcode};
            w_misaligned   = imm[0];
            w_out_of_range = !w_fits21;
        end
    end

    always_comb begin
        w_code = c_err_none;
        if (w_bad_op) begin
            w_code = c_err_op;
        end else if (w_misaligned) begin
            w_code = c_err_align;
        end else if (w_out_of_range) begin
            w_code = c_err_range;
        end
    end

    assign w_full      = (r_count == c_depth);
    assign w_count_inc = r_count + c_one;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
            r_code  <= c_err_none;
            r_we    <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= 32'd0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
            r_code  <= c_err_none;
            r_we    <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inValid && r_ready) begin
                        r_ready <= 1'b0;
                        if (w_code != c_err_none) begin
                            r_err   <= 1'b1;
                            r_code  <= w_code;
                            r_state <= S_ERR;
                        end else begin
                            r_data  <= w_word;
                            r_we    <= 1'b1;
                            r_state <= S_WRITE;
                        end
                    end else begin
                        r_ready <= !w_full && !r_err;
                    end
                end
                S_WRITE: begin
                    if (memAck) begin
                        r_we    <= 1'b0;
                        r_count <= w_count_inc;
                        r_ready <= (w_count_inc != c_depth);
                        r_state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign inReady        = r_ready;
    assign memWriteEnable = r_we;
    assign memWriteData   = r_data;
    assign memWriteAddr   = BASE_ADDR + (32'(r_count) << 2);
    assign count          = r_count;
    assign full           = w_full;
    assign err            = r_err;
    assign errCode        = r_code;

endmodule
`default_nettype wire
